key_poll_master: RTL

- Avalon-MM read-only initiator; the other end of the 2-bit key PIO input slave.
- Every POLL_DIV cycles, issues one read of the PIO data register at address 0.
- Debounces the returned key bits and emits a stable key vector plus one-cycle press/release pulses to user logic.
- Sits between the system interconnect and the game/control FSMs that consume key events.

---
 rtl/key_poll_pkg.sv | 14 +
 rtl/key_debounce.sv | 78 +++++++
 rtl/key_poll_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/key_poll_pkg.sv
// Shared types and constants for the key PIO polling initiator.
package key_poll_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  // Keys are active-low; an idle key reads back as 1.
  localparam logic       KEY_RELEASED  = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Whole-vector debouncer: accepts a new key value after DEBOUNCE_N identical samples
// and emits registered one-cycle press/release pulses on each accepted change.
module key_debounce
  import key_poll_pkg::*;
#(
  parameter int KEY_W      = 2,
  parameter int DEBOUNCE_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [KEY_W-1:0] sample,
  output logic [KEY_W-1:0] keys_stable,
  output logic [KEY_W-1:0] press_pulse,
  output logic [KEY_W-1:0] release_pulse
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_N);

  logic [KEY_W-1:0] last_r, last_next_s;
  logic [KEY_W-1:0] stable_r, stable_next_s;
  logic [KEY_W-1:0] press_r, press_next_s;
  logic [KEY_W-1:0] release_r, release_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;

  // Next-state debounce evaluation for one polled sample.
  always_comb begin
    last_next_s    = last_r;
    stable_next_s  = stable_r;
    cnt_next_s     = cnt_r;
    press_next_s   = '0;
    release_next_s = '0;
    if (sample_valid) begin
      if (sample == last_r) begin
        if (cnt_r == CNT_MAX) begin
          cnt_next_s = CNT_MAX;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_next_s  = CNT_W'(1);
        last_next_s = sample;
      end
      if ((cnt_next_s == CNT_MAX) && (sample != stable_r)) begin
        stable_next_s  = sample;
        press_next_s   = stable_r & ~sample;
        release_next_s = ~stable_r & sample;
      end else begin
        stable_next_s  = stable_r;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Debounce state and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r    <= {KEY_W{KEY_RELEASED}};
      stable_r  <= {KEY_W{KEY_RELEASED}};
      cnt_r     <= '0;
      press_r   <= '0;
      release_r <= '0;
    end else begin
      last_r    <= last_next_s;
      stable_r  <= stable_next_s;
      cnt_r     <= cnt_next_s;
      press_r   <= press_next_s;
      release_r <= release_next_s;
    end
  end

  assign keys_stable   = stable_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

endmodule

// File: rtl/key_poll_master.sv
// Avalon-MM read initiator that polls the key PIO every POLL_DIV cycles and debounces it.
// Defining KEY_POLL_IRQ_EN adds a sticky press interrupt (irq, cleared by irq_ack).
module key_poll_master
  import key_poll_pkg::*;
#(
  parameter int KEY_W      = 2,
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic [KEY_W-1:0] keys_stable,
  output logic [KEY_W-1:0] press_pulse,
  output logic [KEY_W-1:0] release_pulse,
  output logic             timeout_err
`ifdef KEY_POLL_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_ack
`endif
);

  localparam int                DIV_W     = $clog2(POLL_DIV);
  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(POLL_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_r, state_next_s;
  logic [DIV_W-1:0]  div_r;
  logic [WAIT_W-1:0] wait_r, wait_next_s;
  logic              read_r, read_next_s;
  logic              tout_r;
  logic              tick_s, capture_s, abort_s;
  logic [KEY_W-1:0]  sample_r;
  logic              unused_s;

  assign tick_s   = enable && (div_r == DIV_LAST);
  assign unused_s = ^avm_readdata[31:KEY_W];

  // Poll interval counter; held at zero while polling is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
    end else if (!enable || tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Transaction FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    read_next_s  = read_r;
    wait_next_s  = wait_r;
    capture_s    = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_next_s = READ;
          read_next_s  = 1'b1;
          wait_next_s  = '0;
        end else begin
          read_next_s  = 1'b0;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          capture_s    = 1'b1;
          read_next_s  = 1'b0;
          state_next_s = UPDATE;
        end else if (wait_r == WAIT_LAST) begin
          abort_s      = 1'b1;
          read_next_s  = 1'b0;
          state_next_s = IDLE;
        end else begin
          wait_next_s  = wait_r + WAIT_W'(1);
        end
      end
      UPDATE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        read_next_s  = 1'b0;
      end
    endcase
  end

  // FSM, bus strobe, sample capture and sticky abort flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      read_r   <= 1'b0;
      wait_r   <= '0;
      sample_r <= {KEY_W{KEY_RELEASED}};
      tout_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      read_r  <= read_next_s;
      wait_r  <= wait_next_s;
      if (capture_s) begin
        sample_r <= avm_readdata[KEY_W-1:0];
      end
      if (abort_s) begin
        tout_r <= 1'b1;
      end
    end
  end

  assign avm_address = PIO_DATA_ADDR;
  assign avm_read    = read_r;
  assign timeout_err = tout_r;

  key_debounce #(
    .KEY_W      (KEY_W),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (state_r == UPDATE),
    .sample        (sample_r),
    .keys_stable   (keys_stable),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

`ifdef KEY_POLL_IRQ_EN
  logic irq_r;

  // Sticky press interrupt; a new press beats a simultaneous acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else if (|press_pulse) begin
      irq_r <= 1'b1;
    end else if (irq_ack) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end

  assign irq = irq_r;
`endif

endmodule
